// File: rtl/syst_array_nxn.sv
// syst_array_nxn: NxN output-stationary systolic multiplier C = A*B with built-in input skew.
// Optional macro SYST_SAT_EN selects sticky saturating accumulation; default wraps at ACC_W bits.
module syst_array_nxn #(
   parameter int unsigned N      = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ACC_W  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N*DATA_W-1:0]   a_col,
   input  logic [N*DATA_W-1:0]   b_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [N*ACC_W-1:0]    out_row,
   output logic [$clog2(N):0]    out_idx,
   output logic                  busy,
   output logic                  done
);

   localparam int unsigned IDX_W      = $clog2(N) + 1;
   localparam int unsigned CNT_W      = $clog2(2 * N) + 1;
   localparam int unsigned PROD_W     = 2 * DATA_W;
   localparam int unsigned SUM_W      = ACC_W + 1;
   localparam int unsigned BEAT_LAST  = N - 1;
   localparam int unsigned DRAIN_LAST = (N > 1) ? (2 * N - 3) : 0;

`ifdef SYST_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_OUT
   } state_t;

   state_t               state_q;
   state_t               state_nxt;
   logic [IDX_W-1:0]     beat_cnt;
   logic [CNT_W-1:0]     drain_cnt;

   logic                 accept_c;
   logic                 clr_c;
   logic                 run_c;
   logic                 row_take_c;
   logic                 row_last_c;

   logic signed [DATA_W-1:0] a_in   [N];
   logic signed [DATA_W-1:0] b_in   [N];
   logic signed [DATA_W-1:0] w_in   [N][N];
   logic signed [DATA_W-1:0] n_in   [N][N];
   logic signed [ACC_W-1:0]  acc_all[N][N];

   logic [IDX_W-1:0]     row_sel_c;
   logic [N*ACC_W-1:0]   row_data_c;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   // Next-state and control strobes
   always_comb begin
      state_nxt  = state_q;
      accept_c   = 1'b0;
      clr_c      = 1'b0;
      row_take_c = 1'b0;
      row_last_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               clr_c     = 1'b1;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            accept_c = in_valid;
            if (in_valid && (beat_cnt == IDX_W'(BEAT_LAST))) begin
               state_nxt = (N == 1) ? S_OUT : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (drain_cnt == CNT_W'(DRAIN_LAST)) begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            row_take_c = out_valid & out_ready;
            if (row_take_c && (out_idx == IDX_W'(N - 1))) begin
               row_last_c = 1'b1;
               state_nxt  = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign run_c = (state_q == S_LOAD) || (state_q == S_DRAIN);

   // Beat and drain counters
   always_ff @(posedge clk) begin
      if (rst) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (clr_c) begin
            beat_cnt <= '0;
         end else if (accept_c) begin
            beat_cnt <= beat_cnt + IDX_W'(1);
         end
         if (state_q != S_DRAIN) begin
            drain_cnt <= '0;
         end else begin
            drain_cnt <= drain_cnt + CNT_W'(1);
         end
      end
   end

   // Unpack the beat; non-accept cycles inject zero bubbles
   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         a_in[i] = accept_c ? $signed(a_col[i*DATA_W +: DATA_W]) : '0;
         b_in[i] = accept_c ? $signed(b_row[i*DATA_W +: DATA_W]) : '0;
      end
   end

   // Input skew: row i of A and column i of B are delayed by i registers
   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_direct
         assign w_in[0][0] = a_in[0];
         assign n_in[0][0] = b_in[0];
      end else begin : g_dly
         logic signed [DATA_W-1:0] a_dly [i];
         logic signed [DATA_W-1:0] b_dly [i];
         always_ff @(posedge clk) begin
            if (rst || clr_c) begin
               for (int d = 0; d < i; d++) begin
                  a_dly[d] <= '0;
                  b_dly[d] <= '0;
               end
            end else begin
               a_dly[0] <= a_in[i];
               b_dly[0] <= b_in[i];
               for (int d = 1; d < i; d++) begin
                  a_dly[d] <= a_dly[d-1];
                  b_dly[d] <= b_dly[d-1];
               end
            end
         end
         assign w_in[i][0] = a_dly[i-1];
         assign n_in[0][i] = b_dly[i-1];
      end
   end

   // Processing elements
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_pe
         logic signed [ACC_W-1:0]  acc_q;
         logic signed [ACC_W-1:0]  acc_nxt_c;
         logic signed [PROD_W-1:0] prod_c;
         logic signed [ACC_W-1:0]  term_c;

         assign prod_c = PROD_W'(w_in[i][j]) * PROD_W'(n_in[i][j]);
         assign term_c = ACC_W'(prod_c);

`ifdef SYST_SAT_EN
         // Once clamped, the accumulator is frozen until the next start
         logic               sat_q;
         logic               sat_nxt_c;
         logic signed [SUM_W-1:0] sum_c;

         assign sum_c = SUM_W'(acc_q) + SUM_W'(term_c);

         always_comb begin
            acc_nxt_c = acc_q;
            sat_nxt_c = sat_q;
            if (!sat_q) begin
               if (sum_c[ACC_W] != sum_c[ACC_W-1]) begin
                  acc_nxt_c = sum_c[ACC_W] ? ACC_MIN : ACC_MAX;
                  sat_nxt_c = 1'b1;
               end else begin
                  acc_nxt_c = sum_c[ACC_W-1:0];
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst || clr_c) begin
               sat_q <= 1'b0;
            end else if (run_c) begin
               sat_q <= sat_nxt_c;
            end
         end
`else
         always_comb begin
            acc_nxt_c = acc_q + term_c;
         end
`endif

         always_ff @(posedge clk) begin
            if (rst || clr_c) begin
               acc_q <= '0;
            end else if (run_c) begin
               acc_q <= acc_nxt_c;
            end
         end

         assign acc_all[i][j] = acc_q;

         if (j < N - 1) begin : g_east
            logic signed [DATA_W-1:0] east_q;
            always_ff @(posedge clk) begin
               if (rst || clr_c) begin
                  east_q <= '0;
               end else if (run_c) begin
                  east_q <= w_in[i][j];
               end
            end
            assign w_in[i][j+1] = east_q;
         end

         if (i < N - 1) begin : g_south
            logic signed [DATA_W-1:0] south_q;
            always_ff @(posedge clk) begin
               if (rst || clr_c) begin
                  south_q <= '0;
               end else if (run_c) begin
                  south_q <= n_in[i][j];
               end
            end
            assign n_in[i+1][j] = south_q;
         end
      end
   end

   // Row to present next: row 0 on entry to OUT, otherwise the following row
   always_comb begin
      row_sel_c  = out_valid ? (out_idx + IDX_W'(1)) : '0;
      row_data_c = '0;
      for (int unsigned r = 0; r < N; r++) begin
         if (IDX_W'(r) == row_sel_c) begin
            for (int unsigned j = 0; j < N; j++) begin
               row_data_c[j*ACC_W +: ACC_W] = acc_all[r][j];
            end
         end
      end
   end

   // Registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         out_row   <= '0;
      end else begin
         in_ready <= (state_nxt == S_LOAD);
         busy     <= (state_nxt != S_IDLE);
         done     <= row_last_c;
         if ((state_q == S_OUT) && !row_last_c) begin
            if (!out_valid || row_take_c) begin
               out_valid <= 1'b1;
               out_idx   <= row_sel_c;
               out_row   <= row_data_c;
            end
         end else begin
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_row   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_syst_array_nxn.sv
// tb_syst_array_nxn: directed and randomized bench for syst_array_nxn (N=4, DATA_W=16, ACC_W=32).
// Expected results come from a plain matrix-product model; honours SYST_SAT_EN like the design.
`timescale 1ns/1ps
module tb_syst_array_nxn;

   localparam int unsigned N      = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned IDX_W  = $clog2(N) + 1;
   localparam int unsigned W      = N * ACC_W;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 in_valid;
   logic                 in_ready;
   logic [N*DATA_W-1:0]  a_col;
   logic [N*DATA_W-1:0]  b_row;
   logic                 out_valid;
   logic                 out_ready;
   logic [N*ACC_W-1:0]   out_row;
   logic [IDX_W-1:0]     out_idx;
   logic                 busy;
   logic                 done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int     mat_a [N][N];
   int     mat_b [N][N];
   longint exp_c [N][N];
   int     t1    [N][N] = '{'{90, 100, 110, 120}, '{202, 228, 254, 280},
                            '{314, 356, 398, 440}, '{426, 484, 542, 600}};

   syst_array_nxn #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_col     (a_col),
      .b_row     (b_row),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_row   (out_row),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // C[i][j] = sum_k A[i][k]*B[k][j], accumulated in beat order
   function automatic longint model_c(int i, int j);
      longint acc = 0;
      longint p;
      bit     sat = 1'b0;
      for (int k = 0; k < N; k++) begin
         p = longint'(mat_a[i][k]) * longint'(mat_b[k][j]);
`ifdef SYST_SAT_EN
         if (!sat) begin
            acc = acc + p;
            if (acc > 64'sd2147483647) begin
               acc = 64'sd2147483647;
               sat = 1'b1;
            end else if (acc < -64'sd2147483648) begin
               acc = -64'sd2147483648;
               sat = 1'b1;
            end
         end
`else
         acc = longint'(int'(acc + p));
`endif
      end
      return acc;
   endfunction

   task automatic set_model();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            exp_c[i][j] = model_c(i, j);
   endtask

   task automatic set_test1();
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = i * N + j + 1;
            mat_b[i][j] = i * N + j + 1;
            exp_c[i][j] = longint'(t1[i][j]);
         end
   endtask

   function automatic logic [W-1:0] exp_row(int r);
      logic [W-1:0] v = '0;
      for (int j = 0; j < N; j++) v[j*ACC_W +: ACC_W] = ACC_W'(exp_c[r][j]);
      return v;
   endfunction

   task automatic drive_beat(int k);
      for (int i = 0; i < N; i++) a_col[i*DATA_W +: DATA_W] = DATA_W'(mat_a[i][k]);
      for (int j = 0; j < N; j++) b_row[j*DATA_W +: DATA_W] = DATA_W'(mat_b[k][j]);
      in_valid = 1'b1;
   endtask

   // One full multiply: start, N beats with gaps, drain, collect rows with an optional stall
   task automatic run_mult(input int gap, input int stall_row, input int stall_len, input bit noisy);
      int c_last, r, t, stalls, dones;
      bit first, pulsed;
      start    = 1'b1;
      in_valid = noisy;
      a_col    = {$urandom, $urandom};
      b_row    = {$urandom, $urandom};
      step();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("busy_after_start", W'(busy), W'(1));
      chk("in_ready_in_load", W'(in_ready), W'(1));
      for (int k = 0; k < N; k++) begin
         for (int g = 0; g < ((k > 0) ? gap : 0); g++) begin
            in_valid = 1'b0;
            a_col    = {$urandom, $urandom};
            b_row    = {$urandom, $urandom};
            step();
         end
         drive_beat(k);
         start = noisy && (k == 1);
         step();
         start = 1'b0;
      end
      in_valid = 1'b0;
      c_last   = cyc;
      chk("in_ready_after_last", W'(in_ready), W'(0));
      if (noisy) begin
         start = 1'b1;
         step();
         start = 1'b0;
      end
      r = 0; t = 0; stalls = 0; dones = 0; first = 1'b1; pulsed = 1'b0;
      while (r < N && t < 100) begin
         out_ready = 1'b1;
         if (r == stall_row && stalls < stall_len && out_valid) begin
            out_ready = 1'b0;
            stalls++;
         end
         start = 1'b0;
         if (noisy && r == 2 && !pulsed) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         if (done) dones++;
         if (out_valid) begin
            if (first) begin
               chk("first_valid_latency", W'(cyc - c_last), W'(2 * N - 1));
               first = 1'b0;
            end
            chk($sformatf("row%0d_idx", r), W'(out_idx), W'(r));
            chk($sformatf("row%0d_data", r), out_row, exp_row(r));
            if (out_ready) r++;
         end
         step();
         t++;
      end
      start = 1'b0;
      chk("rows_collected", W'(r), W'(N));
      chk("no_early_done", W'(dones), W'(0));
      chk("done_pulse", W'(done), W'(1));
      chk("busy_after_done", W'(busy), W'(0));
      chk("valid_after_done", W'(out_valid), W'(0));
      step();
      chk("done_single", W'(done), W'(0));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a_col = '0; b_row = '0;
      step();
      step();
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_in_ready", W'(in_ready), W'(0));
      chk("rst_done", W'(done), W'(0));
      chk("rst_out_row", out_row, W'(0));
      chk("rst_out_idx", W'(out_idx), W'(0));
      rst = 1'b0;
      step();

      // Back-to-back beats, free-flowing consumer
      set_test1();
      run_mult(0, -1, 0, 1'b0);

      // Two bubble cycles between beats
      run_mult(2, -1, 0, 1'b0);

      // Consumer stalls three cycles on row 1
      run_mult(0, 1, 3, 1'b0);

      // Overflowing operands
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = 32767;
            mat_b[i][j] = 32767;
         end
      set_model();
      run_mult(0, -1, 0, 1'b0);

      // Overflow followed by a large negative product
      for (int i = 0; i < N; i++) mat_a[i][N-1] = -32767;
      set_model();
      run_mult(1, 2, 1, 1'b0);

      // Negative operands
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            mat_a[i][j] = -1;
            mat_b[i][j] = 2;
         end
      set_model();
      run_mult(0, -1, 0, 1'b0);

      // Reset after beat 2, then a clean run
      set_test1();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive_beat(k);
         step();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_in_ready", W'(in_ready), W'(0));
      chk("midrst_out_valid", W'(out_valid), W'(0));
      chk("midrst_done", W'(done), W'(0));
      step();
      step();
      chk("midrst_no_done", W'(done), W'(0));
      run_mult(0, -1, 0, 1'b0);

      // Stray start pulses in every busy state plus an in_valid beat in IDLE
      run_mult(0, -1, 0, 1'b1);

      // Randomized matrices, gaps, stalls
      for (int it = 0; it < 4; it++) begin
         for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
               mat_a[i][j] = int'(shortint'($urandom));
               mat_b[i][j] = int'(shortint'($urandom));
            end
         set_model();
         run_mult(int'($urandom_range(0, 2)), int'($urandom_range(0, N - 1)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
